// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard/forwarding logic: mux selection codes
// and the per-stage destination tag.
package pipeline_pkg;

  // Tag rd storage is wide enough for any supported REG_ADDR_W (<= 8).
  localparam int TAG_RD_W = 8;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_MEM     = 2'd1,
    FWD_WB      = 2'd2
  } forward_sel_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                reg_write;
    logic                is_load;
  } stage_tag_t;

  // True when the stage will write register r.
  function automatic logic tag_writes(input stage_tag_t t, input logic [TAG_RD_W-1:0] r);
    return t.valid & t.reg_write & (t.rd == r);
  endfunction

endpackage

// File: rtl/forward_select.sv
// Operand source selection for one ALU input: youngest matching producer wins,
// x0 and unused sources always read the register file.
module forward_select
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  use_i,
  input  stage_tag_t            mem_tag_i,
  input  stage_tag_t            wb_tag_i,
  output forward_sel_t          sel_o
);

  logic [TAG_RD_W-1:0] src_ext;

  assign src_ext = TAG_RD_W'(src_i);

  always_comb begin
    sel_o = FWD_REGFILE;
    if (use_i && (src_ext != '0)) begin
      if (tag_writes(mem_tag_i, src_ext)) begin
        sel_o = FWD_MEM;
      end else if (tag_writes(wb_tag_i, src_ext)) begin
        sel_o = FWD_WB;
      end else begin
        sel_o = FWD_REGFILE;
      end
    end else begin
      sel_o = FWD_REGFILE;
    end
  end

endmodule

// File: rtl/operand_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks EX/MEM/WB
// destination tags, drives operand mux selections, load-use stall and flush.
module operand_forward_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic                   id_is_load,
  input  logic                   ex_branch_taken,
  output logic [1:0]             fwd_sel_a,
  output logic [1:0]             fwd_sel_b,
  output logic                   stall_fd,
  output logic                   flush_fd,
  output logic [STALL_CNT_W-1:0] stall_count
);

  stage_tag_t             ex_tag_q, ex_tag_d;
  stage_tag_t             mem_tag_q, mem_tag_d;
  stage_tag_t             wb_tag_q, wb_tag_d;
  logic [REG_ADDR_W-1:0]  ex_rs1_q, ex_rs1_d;
  logic [REG_ADDR_W-1:0]  ex_rs2_q, ex_rs2_d;
  logic                   ex_uses_rs1_q, ex_uses_rs1_d;
  logic                   ex_uses_rs2_q, ex_uses_rs2_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic                   load_use;
  logic                   rs1_hit;
  logic                   rs2_hit;
  forward_sel_t           sel_a;
  forward_sel_t           sel_b;

  assign rs1_hit  = id_uses_rs1 & (TAG_RD_W'(id_rs1) == ex_tag_q.rd);
  assign rs2_hit  = id_uses_rs2 & (TAG_RD_W'(id_rs2) == ex_tag_q.rd);
  assign load_use = id_valid & ex_tag_q.valid & ex_tag_q.is_load & ex_tag_q.reg_write
                  & (ex_tag_q.rd != '0) & (rs1_hit | rs2_hit);

  // A redirect squashes the stalled consumer anyway, so flush overrides stall.
  assign flush_fd    = ex_branch_taken;
  assign stall_fd    = load_use & ~ex_branch_taken;
  assign stall_count = stall_cnt_q;
  assign fwd_sel_a   = sel_a;
  assign fwd_sel_b   = sel_b;

  forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
    .src_i     (ex_rs1_q),
    .use_i     (ex_uses_rs1_q),
    .mem_tag_i (mem_tag_q),
    .wb_tag_i  (wb_tag_q),
    .sel_o     (sel_a)
  );

  forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
    .src_i     (ex_rs2_q),
    .use_i     (ex_uses_rs2_q),
    .mem_tag_i (mem_tag_q),
    .wb_tag_i  (wb_tag_q),
    .sel_o     (sel_b)
  );

  always_comb begin
    mem_tag_d     = ex_tag_q;
    wb_tag_d      = mem_tag_q;
    ex_tag_d      = '0;
    ex_rs1_d      = '0;
    ex_rs2_d      = '0;
    ex_uses_rs1_d = 1'b0;
    ex_uses_rs2_d = 1'b0;
    if (flush_fd || stall_fd) begin
      ex_tag_d = '0;
    end else begin
      ex_tag_d.valid     = id_valid;
      ex_tag_d.rd        = TAG_RD_W'(id_rd);
      ex_tag_d.reg_write = id_reg_write;
      ex_tag_d.is_load   = id_is_load;
      ex_rs1_d           = id_rs1;
      ex_rs2_d           = id_rs2;
      ex_uses_rs1_d      = id_uses_rs1;
      ex_uses_rs2_d      = id_uses_rs2;
    end
    if (stall_fd && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_tag_q      <= '0;
      mem_tag_q     <= '0;
      wb_tag_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_uses_rs1_q <= 1'b0;
      ex_uses_rs2_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      ex_tag_q      <= ex_tag_d;
      mem_tag_q     <= mem_tag_d;
      wb_tag_q      <= wb_tag_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_uses_rs1_q <= ex_uses_rs1_d;
      ex_uses_rs2_q <= ex_uses_rs2_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Self-checking bench: directed hazard scenarios then random instruction
// streams, compared against an instruction-history pipeline model.
module tb_operand_forward_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_reg_write, id_uses_rs1, id_uses_rs2, id_is_load, ex_branch_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] fwd_a, fwd_b, s_fwd_a, s_fwd_b;
  logic       stall, flush, s_stall, s_flush;
  logic [31:0] cnt;
  logic [1:0]  s_cnt;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       ld;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
  } instr_t;

  instr_t  stage [3];
  longint  stalls;
  bit      last_stall;
  longint  saved_cnt;

  always #5 clk = ~clk;

  operand_forward_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
    .fwd_sel_a(fwd_a), .fwd_sel_b(fwd_b), .stall_fd(stall), .flush_fd(flush),
    .stall_count(cnt)
  );

  operand_forward_ctrl #(.STALL_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
    .fwd_sel_a(s_fwd_a), .fwd_sel_b(s_fwd_b), .stall_fd(s_stall), .flush_fd(s_flush),
    .stall_count(s_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest older instruction (MEM, then WB) that writes the source wins.
  function automatic logic [1:0] exp_sel(input bit u, input bit [4:0] rs);
    if (!u || rs == 5'd0) return 2'd0;
    for (int d = 1; d <= 2; d++) begin
      if (stage[d].v && stage[d].rw && stage[d].rd == rs) return d[1:0];
    end
    return 2'd0;
  endfunction

  function automatic bit exp_load_use();
    if (!(id_valid && stage[0].v && stage[0].ld && stage[0].rw && stage[0].rd != 5'd0)) return 1'b0;
    return (id_uses_rs1 && id_rs1 == stage[0].rd) || (id_uses_rs2 && id_rs2 == stage[0].rd);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) stage[i] = '{default: '0};
    stalls = 0;
    last_stall = 1'b0;
  endtask

  task automatic check_all();
    bit st;
    longint sat;
    st  = exp_load_use() && !ex_branch_taken;
    sat = (stalls > 3) ? 3 : stalls;
    chk("fwd_sel_a", fwd_a, exp_sel(stage[0].u1, stage[0].rs1));
    chk("fwd_sel_b", fwd_b, exp_sel(stage[0].u2, stage[0].rs2));
    chk("stall_fd", stall, st);
    chk("flush_fd", flush, ex_branch_taken);
    chk("stall_count", cnt, stalls);
    chk("sat_fwd_sel_b", s_fwd_b, exp_sel(stage[0].u2, stage[0].rs2));
    chk("sat_stall_fd", s_stall, st);
    chk("sat_stall_count", s_cnt, sat);
  endtask

  task automatic drive(input bit v, input bit [4:0] rd, input bit rw, input bit ld,
                       input bit [4:0] rs1, input bit u1, input bit [4:0] rs2,
                       input bit u2, input bit br);
    @(negedge clk);
    id_valid = v; id_rd = rd; id_reg_write = rw; id_is_load = ld;
    id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    ex_branch_taken = br;
    #1;
    check_all();
  endtask

  task automatic drive_nop();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic advance();
    bit st;
    @(posedge clk);
    st = exp_load_use() && !ex_branch_taken;
    if (st) stalls++;
    stage[2] = stage[1];
    stage[1] = stage[0];
    if (st || ex_branch_taken) stage[0] = '{default: '0};
    else stage[0] = '{v: id_valid, rd: id_rd, rw: id_reg_write, ld: id_is_load,
                      rs1: id_rs1, rs2: id_rs2, u1: id_uses_rs1, u2: id_uses_rs2};
    last_stall = st;
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    id_valid = 1'b0; id_rd = 5'd0; id_reg_write = 1'b0; id_is_load = 1'b0;
    id_rs1 = 5'd0; id_uses_rs1 = 1'b0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
    ex_branch_taken = 1'b0;
    #3;
    check_all();
    ex_branch_taken = 1'b1;
    #1;
    chk("reset_flush_follows_branch", flush, 1'b1);
    ex_branch_taken = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back ALU dependency
    drive(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1, 0); advance();
    drive(1, 5'd6, 1, 0, 5'd5, 1, 5'd4, 1, 0);
    chk("b2b_no_stall", stall, 1'b0); advance();
    drive_nop();
    chk("b2b_sel_a", fwd_a, 2'd1);
    chk("b2b_sel_b", fwd_b, 2'd0); advance();

    // Distance-2 dependency
    drive(1, 5'd7, 1, 0, 5'd1, 1, 5'd2, 1, 0); advance();
    drive(1, 5'd8, 1, 0, 5'd1, 1, 5'd2, 1, 0); advance();
    drive(1, 5'd10, 1, 0, 5'd1, 1, 5'd7, 1, 0); advance();
    drive_nop();
    chk("dist2_sel_b", fwd_b, 2'd2); advance();

    // Producers of x7 in both MEM and WB
    drive(1, 5'd7, 1, 0, 5'd1, 1, 5'd2, 1, 0); advance();
    drive(1, 5'd7, 1, 0, 5'd2, 1, 5'd3, 1, 0); advance();
    drive(1, 5'd10, 1, 0, 5'd1, 1, 5'd7, 1, 0); advance();
    drive_nop();
    chk("both_match_sel_b", fwd_b, 2'd1); advance();

    // Load-use
    drive(1, 5'd3, 1, 1, 5'd1, 1, 5'd0, 0, 0); advance();
    drive(1, 5'd11, 1, 0, 5'd3, 1, 5'd2, 1, 0);
    chk("lu_stall", stall, 1'b1);
    chk("lu_count_before", cnt, 32'd0); advance();
    drive(1, 5'd11, 1, 0, 5'd3, 1, 5'd2, 1, 0);
    chk("lu_stall_once", stall, 1'b0);
    chk("lu_count_after", cnt, 32'd1); advance();
    drive_nop();
    chk("lu_sel_a_wb", fwd_a, 2'd2); advance();

    // x0 never forwarded
    drive(1, 5'd0, 1, 0, 5'd1, 1, 5'd2, 1, 0); advance();
    drive(1, 5'd12, 1, 0, 5'd0, 1, 5'd0, 1, 0); advance();
    drive_nop();
    chk("x0_sel_a", fwd_a, 2'd0);
    chk("x0_sel_b", fwd_b, 2'd0); advance();

    // Unused source matching a load destination
    drive(1, 5'd13, 1, 1, 5'd1, 1, 5'd0, 0, 0); advance();
    drive(1, 5'd16, 1, 0, 5'd1, 1, 5'd13, 0, 0);
    chk("unused_no_stall", stall, 1'b0); advance();
    drive_nop();
    chk("unused_sel_b", fwd_b, 2'd0); advance();

    // Flush priority over load-use
    drive(1, 5'd14, 1, 1, 5'd1, 1, 5'd0, 0, 0); advance();
    drive(1, 5'd17, 1, 0, 5'd14, 1, 5'd2, 1, 1);
    chk("flush_prio_flush", flush, 1'b1);
    chk("flush_prio_stall", stall, 1'b0);
    saved_cnt = cnt; advance();
    drive_nop();
    chk("flush_count_held", cnt, saved_cnt);
    chk("flush_ex_bubble", fwd_a, 2'd0); advance();

    // Five more stalls: narrow counter saturates
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'd15, 1, 1, 5'd1, 1, 5'd0, 0, 0); advance();
      drive(1, 5'd18, 1, 0, 5'd15, 1, 5'd2, 1, 0); advance();
      drive(1, 5'd18, 1, 0, 5'd15, 1, 5'd2, 1, 0); advance();
    end
    drive_nop();
    chk("sat_count_3", s_cnt, 2'd3);
    chk("wide_count_6", cnt, 32'd6); advance();

    // Async reset in the middle of a stall
    drive(1, 5'd9, 1, 0, 5'd1, 1, 5'd2, 1, 0); advance();
    drive(1, 5'd3, 1, 1, 5'd9, 1, 5'd0, 0, 0); advance();
    drive(1, 5'd4, 1, 0, 5'd3, 1, 5'd3, 1, 0);
    chk("pre_reset_stall", stall, 1'b1);
    chk("pre_reset_sel_a", fwd_a, 2'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_count", cnt, 32'd0);
    chk("rst_sat_count", s_cnt, 2'd0);
    chk("rst_sel_a", fwd_a, 2'd0);
    model_reset();
    id_valid = 1'b0; id_rd = 5'd0; id_reg_write = 1'b0; id_is_load = 1'b0;
    id_rs1 = 5'd0; id_uses_rs1 = 1'b0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Random instruction stream over a small register set
    for (int i = 0; i < 800; i++) begin
      if (last_stall && $urandom_range(0, 3) != 0) begin
        drive(id_valid, id_rd, id_reg_write, id_is_load, id_rs1, id_uses_rs1,
              id_rs2, id_uses_rs2, $urandom_range(0, 9) == 0);
      end else begin
        bit v;
        v = $urandom_range(0, 7) != 0;
        drive(v, 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 2) == 0),
              5'($urandom_range(0, 3)), v & 1'($urandom),
              5'($urandom_range(0, 3)), v & 1'($urandom),
              $urandom_range(0, 9) == 0);
      end
      advance();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/operand_forward_ctrl.md
# operand_forward_ctrl

Hazard and forwarding controller for the 5-stage RISC-V pipeline. It tracks destination-register tags for the EX, MEM and WB stages and drives the 2-bit `selection` inputs of the two 3-input operand multiplexers that feed the EX-stage ALU (regfile / MEM result / WB result). It also raises the load-use stall and the branch flush for the fetch/decode registers, and keeps a saturating stall-cycle counter for performance reporting.

## Interface
- `REG_ADDR_W`, default 5: architectural register index width.
- `STALL_CNT_W`, default 32: width of the stall counter.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `id_valid`  in  1: decode stage holds a real instruction.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W: decode source registers.
- `id_rd`  in  REG_ADDR_W: decode destination register.
- `id_reg_write`  in  1: decode instruction writes `id_rd`.
- `id_uses_rs1`, `id_uses_rs2`  in  1: decode instruction reads that source.
- `id_is_load`  in  1: decode instruction is a load.
- `ex_branch_taken`  in  1: the EX-stage branch or jump redirects fetch this cycle.
- `fwd_sel_a`, `fwd_sel_b`  out  2: selections for the operand A and B muxes.
- `stall_fd`  out  1: hold the PC and the F/D register this cycle.
- `flush_fd`  out  1: squash the F/D register this cycle.
- `stall_count`  out  STALL_CNT_W: total load-use stall cycles, saturating.

## Operation
- Internal tag registers exist for the EX, MEM and WB stages. Each holds `valid`, `rd`, `reg_write`, `is_load`. EX also holds `rs1`, `rs2`, `uses_rs1` and `uses_rs2`.
- **Load-use hazard:** `load_use` = `id_valid` & EX.valid & EX.is_load & EX.reg_write & EX.rd≠0 & ((`id_uses_rs1` & `id_rs1`==EX.rd) | (`id_uses_rs2` & `id_rs2`==EX.rd)).
- `flush_fd` = `ex_branch_taken`.
- `stall_fd` = `load_use` & ~`ex_branch_taken`. Flush has priority over stall.
- **Tag advance, every rising edge:** WB←MEM and MEM←EX, unconditionally.
- **EX update:**
  - EX←bubble (valid=0) if `flush_fd` or `stall_fd`.
  - Otherwise EX←decode inputs, with valid=`id_valid`.
- **Operand A selection:**
  - `FWD_MEM` if EX.uses_rs1 & EX.rs1≠0 & MEM.valid & MEM.reg_write & MEM.rd==EX.rs1.
  - Else `FWD_WB` under the same condition against WB.
  - Else `FWD_REGFILE`.
- Operand B selection uses the same rule with rs2.
- MEM wins over WB when both match, so the youngest producer is forwarded.
- A matching MEM-stage load never occurs, because the load-use stall guarantees it. No special case is required.
- x0 is never forwarded. Selection is `FWD_REGFILE` whenever the source index is 0.
- **Stall counter:** `stall_count` increments by 1 on each edge where `stall_fd`=1. It saturates at all-ones and never wraps.

## Timing
- **Reset** (asynchronous assert, synchronous-edge release): all tag valids=0, `stall_count`=0.
- **Outputs during and after reset:** `fwd_sel_a`=`fwd_sel_b`=`FWD_REGFILE`, `stall_fd`=0, `flush_fd`=`ex_branch_taken` (combinational).
- **Output timing:**
  - `fwd_sel_*` are combinational from the registered tags only, and valid in the same cycle the consumer sits in EX.
  - `stall_fd` and `flush_fd` are combinational from the inputs plus the EX tag, so they are valid in the same cycle.
- **Load-use:** exactly one stall cycle per load-use pair. On the next cycle the load is in MEM, a bubble is in EX, decode is unchanged and `load_use`=0.
- **Simultaneous flush and load-use:** `flush_fd`=1, `stall_fd`=0, the counter does not increment, and EX becomes a bubble.
- **Reset mid-stall:** the stall drops immediately and no tags survive.

## Structure
- Shared package `pipeline_pkg` holds:
  - `forward_sel_t`, a 2-bit enum: `FWD_REGFILE`=0, `FWD_MEM`=1, `FWD_WB`=2. The value 3 is unused and never driven.
  - `stage_tag_t`, a struct: `valid`, `rd`, `reg_write`, `is_load`.
- One sub-module, `forward_select`: purely combinational. It takes one source index, its use flag and the MEM/WB tags, and returns `forward_sel_t`. It is instantiated twice, for A and B.

## Test plan
- **Back-to-back ALU dependency:** `add x5` then `sub` reading rs1=x5 → in the consumer's EX cycle, `fwd_sel_a`=1, `fwd_sel_b`=0, no stall.
- **Distance-2 dependency, plus a both-match case:**
  - Producer x7, one unrelated instruction, then consumer rs2=x7 → `fwd_sel_b`=2.
  - With producers x7 in both MEM and WB → `fwd_sel_b`=1.
- **Load-use:** `lw x3` then `add` with rs1=x3 → `stall_fd`=1 for exactly one cycle and `stall_count` goes 0→1. The next cycle has `fwd_sel_a`=2 (load now in WB).
- **x0 and unused source:** producer rd=x0 and consumer rs1=x0 → selection stays 0. Consumer with `id_uses_rs2`=0 and a matching rs2 → `fwd_sel_b`=0 and no stall.
- **Flush priority and saturation:**
  - Load-use condition coincident with `ex_branch_taken`=1 → `flush_fd`=1, `stall_fd`=0, counter unchanged.
  - With STALL_CNT_W=2, five stalls → `stall_count`=3.
- **Async reset mid-stall:** assert `reset` between edges during a stall → `stall_fd`=0 and `stall_count`=0 immediately, and selections return to 0.
